// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus widths, FSM state
// encoding, wait-counter width and the latched request payload.
package dmem_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned WAIT_W = 4;   // holds WAIT_CYCLES in 0..15

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Request fields captured in IDLE and held for the whole access.
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } dmem_req_t;

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous 32-bit RAM with per-byte write enables.
// Ports: clk; addr word index; be byte enables (be[3] = bits 31:24);
//        wdata write word; rdata registered read of addr (read-before-write).
module dmem_bank
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [SEL_W-1:0]      be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes and an unconditional registered read every cycle.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one access at a time from the memory stage,
// inserts WAIT_CYCLES wait states, performs the read/write and pulses ack_o.
// Ports: clk, rst (async, active-low); ce_i/we_i/addr_i/sel_i/data_i request;
//        flush_i aborts an in-flight access; data_o registered read word;
//        ack_o one-cycle completion; stallreq_o combinational stall request.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_o,
  output logic              stallreq_o
);

  state_e                  state_q, state_d;
  logic [WAIT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q;
  dmem_req_t               req_q;
  logic                    capture, access;
  logic [ADDR_WIDTH-1:0]   bank_addr;
  logic [SEL_W-1:0]        bank_be;
  logic [DATA_W-1:0]       bank_rdata;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{addr_i[ADDR_W-1:ADDR_WIDTH+2], addr_i[1:0]};

  // Next-state, wait counter and stall request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    access     = 1'b0;
    stallreq_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ce_i && !flush_i) begin
          capture    = 1'b1;
          cnt_d      = WAIT_W'(WAIT_CYCLES);
          state_d    = ST_BUSY;
          stallreq_o = 1'b1;
        end
      end
      ST_BUSY: begin
        stallreq_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;              // flush beats the access cycle too
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          access  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;          // ce_i here is the request just served
      default: state_d = ST_IDLE;
    endcase
  end

  // The bank reads the incoming address while idle so its registered output
  // already holds the addressed word on the access cycle, even with no waits.
  assign bank_addr = (state_q == ST_IDLE) ? addr_i[ADDR_WIDTH+1:2] : idx_q;
  assign bank_be   = (access && req_q.we) ? req_q.sel : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      req_q   <= '0;
      data_o  <= '0;
      ack_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_o   <= access;
      if (capture) begin
        idx_q <= addr_i[ADDR_WIDTH+1:2];
        req_q <= '{we: we_i, sel: sel_i, data: data_i};
      end
      if (access && !req_q.we) data_o <= bank_rdata;
    end
  end

  dmem_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
    .clk   (clk),
    .addr  (bank_addr),
    .be    (bank_be),
    .wdata (req_q.data),
    .rdata (bank_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (1 and 0 wait states) driven by
// directed and random traffic, checked each cycle against a timeline model.
module tb_dmem_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned WC0 = 1;
  localparam int unsigned WC1 = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce[2], we[2], flush[2], ack[2], stall[2];
  logic [31:0] addr[2], din[2], dout[2];
  logic [3:0]  sel[2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC0)) u_w1 (
    .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .addr_i(addr[0]),
    .sel_i(sel[0]), .data_i(din[0]), .flush_i(flush[0]), .data_o(dout[0]),
    .ack_o(ack[0]), .stallreq_o(stall[0]));

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC1)) u_w0 (
    .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .addr_i(addr[1]),
    .sel_i(sel[1]), .data_i(din[1]), .flush_i(flush[1]), .data_o(dout[1]),
    .ack_o(ack[1]), .stallreq_o(stall[1]));

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc%0d: got %h want %h", nm, i, cyc, act, exp);
    end
  endtask

  function automatic int wc(input int i);
    return (i == 0) ? int'(WC0) : int'(WC1);
  endfunction

  // Timeline model: an accepted request at cycle c stalls through c+W+1,
  // commits at the end of c+W+1 and acks at c+W+2 unless flushed first.
  logic [31:0] mem_m[2][1024];
  bit          kn[2][1024];
  bit          pend[2];
  int          ack_cyc[2];
  bit          l_we[2];
  int          l_idx[2];
  logic [3:0]  l_sel[2];
  logic [31:0] l_dat[2];
  logic [31:0] exp_d[2];
  bit          dkn[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; exp_d[i] = '0; dkn[i] = 1'b1; ack_cyc[i] = 0;
      for (int w = 0; w < 1024; w++) kn[i][w] = 1'b0;
    end
  end

  always @(negedge clk) begin : cmp_p
    bit e_ack, e_stall, done_now;
    for (int i = 0; i < 2; i++) begin
      done_now = 1'b0;
      if (!rst) begin
        pend[i] = 1'b0; exp_d[i] = '0; dkn[i] = 1'b1;
      end else if (pend[i] && cyc == ack_cyc[i]) begin
        done_now = 1'b1;
        if (l_we[i]) begin
          for (int b = 0; b < 4; b++)
            if (l_sel[i][b]) mem_m[i][l_idx[i]][8*b +: 8] = l_dat[i][8*b +: 8];
          if (l_sel[i] == 4'hF) kn[i][l_idx[i]] = 1'b1;
        end else begin
          exp_d[i] = mem_m[i][l_idx[i]];
          dkn[i]   = kn[i][l_idx[i]];
        end
      end
      e_ack   = done_now;
      e_stall = pend[i] ? (cyc < ack_cyc[i]) : (ce[i] && !flush[i]);
      chk("ack", i, 32'(ack[i]), 32'(e_ack));
      chk("stall", i, 32'(stall[i]), 32'(e_stall));
      if (dkn[i]) chk("data", i, dout[i], exp_d[i]);
      if (rst) begin
        if (!pend[i]) begin
          if (ce[i] && !flush[i]) begin
            pend[i]    = 1'b1;
            ack_cyc[i] = cyc + wc(i) + 2;
            l_we[i]    = we[i];
            l_idx[i]   = int'(addr[i][AW+1:2]);
            l_sel[i]   = sel[i];
            l_dat[i]   = din[i];
          end
        end else if (cyc < ack_cyc[i]) begin
          if (flush[i]) pend[i] = 1'b0;
        end else begin
          pend[i] = 1'b0;
        end
      end
    end
  end

  // One request held until ack; returns read word, latency and stall cycles.
  task automatic xfer(input int i, input bit w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] r, output int lat, output int nst);
    lat = -1; nst = 0; r = '0;
    @(posedge clk); #1;
    ce[i] = 1'b1; we[i] = w; addr[i] = a; sel[i] = s; din[i] = d; flush[i] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (stall[i]) nst++;
      if (ack[i]) begin lat = n; r = dout[i]; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ce[i] = 1'b0;
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL xfer_timeout inst%0d: got no ack want ack", i);
    end
  endtask

  logic [31:0] r;
  int lat, nst;

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ce[i] = 0; we[i] = 0; flush[i] = 0; addr[i] = '0; din[i] = '0; sel[i] = '0;
    end
    #1;
    chk("rst_data", 0, dout[0], 32'h0);
    chk("rst_ack", 0, 32'(ack[0]), 32'h0);
    chk("rst_stall", 0, 32'(stall[0]), 32'h0);
    #20;
    @(posedge clk); #3; rst = 1'b1;

    // Preload words 0..15 of both instances.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++)
        xfer(i, 1'b1, 32'(w) << 2, 4'hF, $urandom, r, lat, nst);

    // Full-word write then read, one wait state.
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hA1B2C3D4, r, lat, nst);
    chk("w_lat", 0, 32'(lat), 32'd3);
    chk("w_nstall", 0, 32'(nst), 32'd3);
    xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, r, lat, nst);
    chk("r_lat", 0, 32'(lat), 32'd3);
    chk("r_nstall", 0, 32'(nst), 32'd3);
    chk("r_data", 0, r, 32'hA1B2C3D4);

    // Single byte lane (bits 23:16) merge, then an empty-mask write.
    xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344, r, lat, nst);
    xfer(0, 1'b1, 32'h21, 4'b0100, 32'hEEEEEEEE, r, lat, nst);
    xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, r, lat, nst);
    chk("lane_data", 0, r, 32'h11EE3344);
    xfer(0, 1'b1, 32'h22, 4'b0000, 32'hFFFFFFFF, r, lat, nst);
    chk("sel0_lat", 0, 32'(lat), 32'd3);
    xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, r, lat, nst);
    chk("sel0_data", 0, r, 32'h11EE3344);

    // Flush on the final wait cycle of a write.
    xfer(0, 1'b1, 32'h40, 4'hF, 32'h0, r, lat, nst);
    @(posedge clk); #1;
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; sel[0] = 4'hF; din[0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1; flush[0] = 1'b1;
    @(negedge clk); chk("fl_stall_busy", 0, 32'(stall[0]), 32'h1);
    @(posedge clk); #1; flush[0] = 1'b0; ce[0] = 1'b0;
    @(negedge clk);
    chk("fl_ack", 0, 32'(ack[0]), 32'h0);
    chk("fl_idle", 0, 32'(stall[0]), 32'h0);
    @(negedge clk); chk("fl_ack2", 0, 32'(ack[0]), 32'h0);
    xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, r, lat, nst);
    chk("fl_word", 0, r, 32'h00000000);

    // Asynchronous reset in the middle of a read.
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, r, lat, nst);
    @(posedge clk); #1;
    ce[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20; sel[0] = 4'hF;
    @(posedge clk); #1; ce[0] = 1'b0;
    #2; rst = 1'b0; #1;
    chk("arst_data", 0, dout[0], 32'h0);
    chk("arst_ack", 0, 32'(ack[0]), 32'h0);
    chk("arst_stall", 0, 32'(stall[0]), 32'h0);
    @(posedge clk); #3; rst = 1'b1;
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, r, lat, nst);
    chk("post_rst_lat", 0, 32'(lat), 32'd3);
    chk("post_rst_data", 0, r, 32'hA1B2C3D4);

    // Zero wait states and address wrap.
    xfer(1, 1'b1, 32'h1000, 4'hF, 32'h5, r, lat, nst);
    chk("wrap_w_lat", 1, 32'(lat), 32'd2);
    xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, r, lat, nst);
    chk("wrap_r_lat", 1, 32'(lat), 32'd2);
    chk("wrap_data", 1, r, 32'h00000005);

    // Random traffic on both instances; inputs change every cycle.
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        ce[i]    = 1'($urandom_range(0, 1));
        we[i]    = 1'($urandom_range(0, 1));
        sel[i]   = 4'($urandom);
        din[i]   = $urandom;
        addr[i]  = (32'($urandom) & 32'hFFFF_F000) |
                   (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        flush[i] = ($urandom_range(0, 7) == 0);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin ce[i] = 0; flush[i] = 0; end
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, meaning word-index bits; storage holds 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, meaning extra wait states inserted before each access (0..15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low (asserted when 0).
REQ-005 ce_i  input  1  access request from the memory stage.
REQ-006 we_i  input  1  1 = write, 0 = read.
REQ-007 addr_i  input  32  byte address; bits [ADDR_WIDTH+1:2] select the word, others ignored.
REQ-008 sel_i  input  4  byte-lane enables, big-endian: sel_i[3] = bits 31:24 (byte offset 00), sel_i[0] = bits 7:0 (offset 11).
REQ-009 data_i  input  32  write data, already lane-replicated by requester.
REQ-010 flush_i  input  1  abort the in-flight access (exception or pipeline flush).
REQ-011 data_o  output  32  read word, registered.
REQ-012 ack_o  output  1  one-cycle completion pulse.
REQ-013 stallreq_o  output  1  pipeline stall request while an access is outstanding.

Function
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 IDLE with ce_i=1 and flush_i=0: latch addr, sel, we and data; load wait counter with WAIT_CYCLES; go to BUSY.
REQ-016 IDLE with ce_i=0 or flush_i=1: stay IDLE, capture nothing.
REQ-017 BUSY, counter != 0: decrement counter, stay BUSY.
REQ-018 BUSY, counter == 0: perform the access; go to DONE.
REQ-019 Write access: only bytes with latched sel bit 1 are updated; sel 0000 completes normally with no storage change.
REQ-020 Read access: data_o loaded with the full addressed word regardless of sel; lane extraction is the requester's job.
REQ-021 DONE: ack_o=1 for exactly that cycle; return to IDLE unconditionally; ce_i in DONE is treated as the already-served request.
REQ-022 stallreq_o = (IDLE and ce_i and not flush_i) or BUSY; 0 in DONE; combinational.
REQ-023 Latency: request seen in IDLE at cycle 0; ack_o and valid data_o at cycle WAIT_CYCLES+2; stallreq_o high for WAIT_CYCLES+2 cycles.
REQ-024 flush_i=1 in BUSY: return to IDLE next edge, no write performed, data_o unchanged, no ack_o; this applies on the access cycle too (flush wins over access).
REQ-025 flush_i in DONE: ignored; access already committed.
REQ-026 data_o holds its value until the next completed read.
REQ-027 Addresses beyond storage wrap modulo 2**ADDR_WIDTH words; no error signalled.
REQ-028 Back-to-back requests: minimum spacing is one IDLE cycle between DONE and the next capture.

Reset
REQ-029 On rst=0, asynchronously: state IDLE, counter 0, latched request cleared, data_o 0, ack_o 0; stallreq_o therefore 0 unless ce_i is high.
REQ-030 Storage contents are not reset.
REQ-031 Reset during BUSY aborts the access; no partial write.

Structure
REQ-032 FSM state encodings and the WAIT_CYCLES counter width live in the shared defines file alongside the existing bus-width macros.
REQ-033 One sub-module, dmem_bank: single-port synchronous 32-bit RAM with four byte write-enables, instantiated once.

Verification
REQ-034 WAIT_CYCLES=1, write addr 0x10 data 0xA1B2C3D4 sel 1111, then read 0x10 -> ack_o at cycle 3 each access, data_o=0xA1B2C3D4, stallreq_o high cycles 0-2.
REQ-035 Word preset 0x11223344, write data 0xEEEEEEEE at addr 0x21 sel 0100 -> read returns 0x11EE3344.
REQ-036 Flush asserted in the final BUSY cycle of a write of 0xFFFFFFFF to a word holding 0 -> no ack_o, state IDLE next edge, word still 0x00000000.
REQ-037 Reset pulse mid-BUSY of a read -> data_o=0, ack_o=0, stallreq_o=0 immediately, next request served normally.
REQ-038 WAIT_CYCLES=0, ADDR_WIDTH=10, write 0x5 to addr 0x1000, read addr 0x0 -> 0x00000005 (wrap), ack_o at cycle 2.
